// File: rtl/mem_wb_port.sv
// mem_wb_port: M-stage data-memory access and M/W pipeline register with
// W-stage load extraction and register-file write-back.
//
// The M side is purely combinational: the external memory samples the
// byte enables and replicated store data at the same posedge that moves
// the instruction into W. The raw memory word is captured into the M/W
// register alongside the control fields. Load alignment and sign/zero
// extension are done in W.

module mem_wb_port #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,

    // M-stage instruction
    input  logic        m_valid,
    input  logic [31:0] m_pc,
    input  logic [3:0]  m_op,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_store_data,
    input  logic        m_reg_we,
    input  logic [4:0]  m_rd,
    input  logic [31:0] m_alu_result,

    // external data-memory port
    output logic [31:0] m_data_addr,
    output logic [31:0] m_data_wdata,
    output logic [3:0]  m_data_byteen,
    input  logic [31:0] m_data_rdata,
    output logic [31:0] m_inst_addr,
    output logic        m_align_err,

    // W-stage register-file write port and trace
    output logic        w_grf_we,
    output logic [4:0]  w_grf_addr,
    output logic [31:0] w_grf_wdata,
    output logic [31:0] w_inst_addr
);

    // Memory operation encoding; 9..15 behave like OP_NONE.
    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_LW   = 4'd1;
    localparam logic [3:0] OP_LH   = 4'd2;
    localparam logic [3:0] OP_LHU  = 4'd3;
    localparam logic [3:0] OP_LB   = 4'd4;
    localparam logic [3:0] OP_LBU  = 4'd5;
    localparam logic [3:0] OP_SW   = 4'd6;
    localparam logic [3:0] OP_SH   = 4'd7;
    localparam logic [3:0] OP_SB   = 4'd8;

    // ------------------------------------------------------------------
    // M stage: decode and alignment
    // ------------------------------------------------------------------
    logic [1:0] m_off;
    logic       m_is_load;
    logic       m_is_store;
    logic       m_misaligned;

    assign m_off = m_addr[1:0];

    // Classify the op and flag accesses that cross their natural boundary.
    always_comb begin
        m_is_load    = 1'b0;
        m_is_store   = 1'b0;
        m_misaligned = 1'b0;
        case (m_op)
            OP_LW: begin
                m_is_load    = 1'b1;
                m_misaligned = (m_off != 2'b00);
            end
            OP_LH, OP_LHU: begin
                m_is_load    = 1'b1;
                m_misaligned = m_off[0];
            end
            OP_LB, OP_LBU: begin
                m_is_load    = 1'b1;
            end
            OP_SW: begin
                m_is_store   = 1'b1;
                m_misaligned = (m_off != 2'b00);
            end
            OP_SH: begin
                m_is_store   = 1'b1;
                m_misaligned = m_off[0];
            end
            OP_SB: begin
                m_is_store   = 1'b1;
            end
            default: begin
                m_is_load    = 1'b0;
                m_is_store   = 1'b0;
                m_misaligned = 1'b0;
            end
        endcase
    end

    assign m_align_err = m_valid & m_misaligned;
    assign m_data_addr = m_addr;
    assign m_inst_addr = m_pc;

    // ------------------------------------------------------------------
    // M stage: store lane replication and byte enables
    // ------------------------------------------------------------------
    logic [31:0] sb_wdata;
    logic [31:0] sh_wdata;
    logic [3:0]  sb_lane_en;
    logic [3:0]  sh_lane_en;

    // Each lane carries the byte (or half-lane) it would receive for a
    // sub-word store, so the enables alone pick the destination bytes.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_store_lane
            assign sb_wdata[8*gi +: 8] = m_store_data[7:0];
            assign sh_wdata[8*gi +: 8] = m_store_data[8*(gi%2) +: 8];
            assign sb_lane_en[gi]      = (m_off == 2'(gi));
            assign sh_lane_en[gi]      = (m_off[1] == ((gi / 2) != 0));
        end
    endgenerate

    // Drive the memory write port; anything that is not a legal store
    // leaves all byte enables low and passes the raw store data through.
    always_comb begin
        m_data_byteen = 4'b0000;
        m_data_wdata  = m_store_data;
        if (m_valid && !m_misaligned) begin
            case (m_op)
                OP_SW: begin
                    m_data_byteen = 4'b1111;
                    m_data_wdata  = m_store_data;
                end
                OP_SH: begin
                    m_data_byteen = sh_lane_en;
                    m_data_wdata  = sh_wdata;
                end
                OP_SB: begin
                    m_data_byteen = sb_lane_en;
                    m_data_wdata  = sb_wdata;
                end
                default: begin
                    m_data_byteen = 4'b0000;
                    m_data_wdata  = m_store_data;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // M/W pipeline register
    // ------------------------------------------------------------------
    logic        valid_reg,      valid_next;
    logic [3:0]  op_reg,         op_next;
    logic [1:0]  off_reg,        off_next;
    logic [4:0]  rd_reg,         rd_next;
    logic        reg_we_reg,     reg_we_next;
    logic [31:0] alu_result_reg, alu_result_next;
    logic [31:0] pc_reg,         pc_next;
    logic [31:0] raw_reg,        raw_next;
    logic        err_reg,        err_next;

    // Next-state of the M/W register. A store never writes the GRF even
    // if reg_we is (illegally) set, so the enable is masked at capture.
    always_comb begin
        valid_next      = m_valid;
        op_next         = m_op;
        off_next        = m_off;
        rd_next         = m_rd;
        reg_we_next     = m_reg_we & ~m_is_store;
        alu_result_next = m_alu_result;
        pc_next         = m_pc;
        raw_next        = m_data_rdata;
        err_next        = m_align_err;
    end

    // The register advances every cycle; reset drops whatever was in M.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg      <= 1'b0;
            op_reg         <= OP_NONE;
            off_reg        <= 2'b00;
            rd_reg         <= 5'd0;
            reg_we_reg     <= 1'b0;
            alu_result_reg <= 32'd0;
            pc_reg         <= PC_RESET;
            raw_reg        <= 32'd0;
            err_reg        <= 1'b0;
        end else begin
            valid_reg      <= valid_next;
            op_reg         <= op_next;
            off_reg        <= off_next;
            rd_reg         <= rd_next;
            reg_we_reg     <= reg_we_next;
            alu_result_reg <= alu_result_next;
            pc_reg         <= pc_next;
            raw_reg        <= raw_next;
            err_reg        <= err_next;
        end
    end

    // ------------------------------------------------------------------
    // W stage: load extraction
    // ------------------------------------------------------------------
    logic [7:0]  raw_byte [4];
    logic [15:0] raw_half [2];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_value;
    logic        w_is_load;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_raw_byte
            assign raw_byte[gi] = raw_reg[8*gi +: 8];
        end
        for (genvar gi = 0; gi < 2; gi++) begin : g_raw_half
            assign raw_half[gi] = raw_reg[16*gi +: 16];
        end
    endgenerate

    assign sel_byte = raw_byte[off_reg];
    assign sel_half = raw_half[off_reg[1]];

    // Pick the addressed byte/half out of the captured word and extend it.
    always_comb begin
        load_value = raw_reg;
        w_is_load  = 1'b1;
        case (op_reg)
            OP_LW:   load_value = raw_reg;
            OP_LH:   load_value = {{16{sel_half[15]}}, sel_half};
            OP_LHU:  load_value = {16'd0, sel_half};
            OP_LB:   load_value = {{24{sel_byte[7]}}, sel_byte};
            OP_LBU:  load_value = {24'd0, sel_byte};
            default: w_is_load  = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // W stage: register-file write-back and trace
    // ------------------------------------------------------------------
    // Writes to $zero are suppressed here so the GRF need not filter them.
    always_comb begin
        w_grf_we    = valid_reg & ~err_reg & (w_is_load | reg_we_reg) & (rd_reg != 5'd0);
        w_grf_addr  = rd_reg;
        w_grf_wdata = w_is_load ? load_value : alu_result_reg;
        w_inst_addr = pc_reg;
    end

endmodule

// File: tb/tb_mem_wb_port.sv
// Bench for mem_wb_port: directed scenarios followed by randomized traffic
// checked against an arithmetic reference model of the memory port.

module tb_mem_wb_port;

    localparam logic [31:0] PC_RESET = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_valid;
    logic [31:0] m_pc;
    logic [3:0]  m_op;
    logic [31:0] m_addr;
    logic [31:0] m_store_data;
    logic        m_reg_we;
    logic [4:0]  m_rd;
    logic [31:0] m_alu_result;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_data_rdata;
    logic [31:0] m_inst_addr;
    logic        m_align_err;
    logic        w_grf_we;
    logic [4:0]  w_grf_addr;
    logic [31:0] w_grf_wdata;
    logic [31:0] w_inst_addr;

    int errors = 0;
    int checks = 0;

    // Data memory (256 bytes) owned by the bench, plus the model's own image.
    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];

    always #5 clk = ~clk;

    mem_wb_port #(.PC_RESET(PC_RESET)) dut (
        .clk           (clk),
        .reset         (reset),
        .m_valid       (m_valid),
        .m_pc          (m_pc),
        .m_op          (m_op),
        .m_addr        (m_addr),
        .m_store_data  (m_store_data),
        .m_reg_we      (m_reg_we),
        .m_rd          (m_rd),
        .m_alu_result  (m_alu_result),
        .m_data_addr   (m_data_addr),
        .m_data_wdata  (m_data_wdata),
        .m_data_byteen (m_data_byteen),
        .m_data_rdata  (m_data_rdata),
        .m_inst_addr   (m_inst_addr),
        .m_align_err   (m_align_err),
        .w_grf_we      (w_grf_we),
        .w_grf_addr    (w_grf_addr),
        .w_grf_wdata   (w_grf_wdata),
        .w_inst_addr   (w_inst_addr)
    );

    assign m_data_rdata = mem[m_data_addr[7:2]];

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (m_data_byteen[i])
                mem[m_data_addr[7:2]][8*i +: 8] <= m_data_wdata[8*i +: 8];
    end

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] data, input logic we, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] pc);
        m_valid = v; m_op = op; m_addr = addr; m_store_data = data;
        m_reg_we = we; m_rd = rd; m_alu_result = alu; m_pc = pc;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic ref_misaligned(input logic [3:0] op, input logic [31:0] addr);
        int unsigned o = addr % 4;
        if (op == 1 || op == 6) return o != 0;
        if (op == 2 || op == 3 || op == 7) return (o % 2) != 0;
        return 1'b0;
    endfunction

    function automatic logic [35:0] ref_store(input logic v, input logic [3:0] op,
                                              input logic [31:0] addr, input logic [31:0] d);
        int unsigned o  = addr % 4;
        logic [31:0] lo16 = d & 32'hFFFF;
        logic [31:0] lo8  = d & 32'hFF;
        if (!v || ref_misaligned(op, addr)) return {4'b0000, d};
        if (op == 6) return {4'b1111, d};
        if (op == 7) return {(o == 0) ? 4'b0011 : 4'b1100, lo16 * 32'h0001_0001};
        if (op == 8) return {4'(1 << o), lo8 * 32'h0101_0101};
        return {4'b0000, d};
    endfunction

    function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] addr,
                                             input logic [31:0] w);
        int unsigned o = addr % 4;
        logic [31:0] b = (w >> (8 * o)) & 32'hFF;
        logic [31:0] h = (w >> (16 * (o / 2))) & 32'hFFFF;
        case (op)
            4'd1: return w;
            4'd2: return (h >= 32'h8000) ? h + 32'hFFFF_0000 : h;
            4'd3: return h;
            4'd4: return (b >= 32'h80) ? b + 32'hFFFF_FF00 : b;
            4'd5: return b;
            default: return 32'd0;
        endcase
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0);
        next_cycle();
        next_cycle();
        checks++;
        if ({w_grf_we, w_grf_addr, w_grf_wdata, w_inst_addr} !== {1'b0, 5'd0, 32'd0, PC_RESET}) begin
            errors++;
            $display("FAIL reset_w: got we=%b addr=%0d wdata=%h pc=%h expected 0/0/0/%h",
                     w_grf_we, w_grf_addr, w_grf_wdata, w_inst_addr, PC_RESET);
        end
        checks++;
        if (m_data_byteen !== 4'b0000) begin
            errors++;
            $display("FAIL reset_byteen: got %b expected 0000", m_data_byteen);
        end
        reset = 1'b0;
        $display("txn reset: w_inst_addr=%h", w_inst_addr);
    endtask

    task automatic test_store_word();
        drive(1'b1, 4'd6, 32'h10, 32'h1234_5678, 1'b0, 5'd3, 32'h0, 32'h0000_0100);
        #1;
        checks++;
        if ({m_data_byteen, m_data_wdata, m_inst_addr} !== {4'b1111, 32'h1234_5678, 32'h0000_0100}) begin
            errors++;
            $display("FAIL sw_port: got be=%b wdata=%h iaddr=%h expected 1111/12345678/00000100",
                     m_data_byteen, m_data_wdata, m_inst_addr);
        end
        next_cycle();
        checks++;
        if (w_grf_we !== 1'b0) begin
            errors++;
            $display("FAIL sw_no_wb: got we=%b expected 0", w_grf_we);
        end
        $display("txn sw addr=10 data=12345678");
    endtask

    task automatic test_store_sub();
        drive(1'b1, 4'd8, 32'h23, 32'h0000_00AB, 1'b0, 5'd0, 32'h0, 32'h104);
        #1;
        checks++;
        if ({m_data_byteen, m_data_wdata} !== {4'b1000, 32'hABAB_ABAB}) begin
            errors++;
            $display("FAIL sb_port: got be=%b wdata=%h expected 1000/abababab", m_data_byteen, m_data_wdata);
        end
        next_cycle();
        drive(1'b1, 4'd7, 32'h22, 32'h0000_BEEF, 1'b0, 5'd0, 32'h0, 32'h108);
        #1;
        checks++;
        if ({m_data_byteen, m_data_wdata} !== {4'b1100, 32'hBEEF_BEEF}) begin
            errors++;
            $display("FAIL sh_port: got be=%b wdata=%h expected 1100/beefbeef", m_data_byteen, m_data_wdata);
        end
        next_cycle();
        $display("txn sb/sh to word 0x20");
    endtask

    task automatic test_load_ext();
        logic [3:0]  ops  [6] = '{4'd4, 4'd4, 4'd5, 4'd2, 4'd3, 4'd1};
        logic [1:0]  offs [6] = '{2'd0, 2'd3, 2'd3, 2'd2, 2'd0, 2'd0};
        logic [31:0] exps [6] = '{32'h0000_0001, 32'hFFFF_FF80, 32'h0000_0080,
                                  32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
        mem[16] = 32'h80FF_7F01;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, ops[i], 32'h40 + 32'(offs[i]), 32'h0, 1'b0, 5'd8, 32'h0, 32'h200 + 32'(4 * i));
            next_cycle();
            checks++;
            if ({w_grf_we, w_grf_addr, w_grf_wdata} !== {1'b1, 5'd8, exps[i]}) begin
                errors++;
                $display("FAIL load_ext_%0d: got we=%b addr=%0d wdata=%h expected 1/8/%h",
                         i, w_grf_we, w_grf_addr, w_grf_wdata, exps[i]);
            end
            $display("txn load op=%0d o=%0d wdata=%h", ops[i], offs[i], w_grf_wdata);
        end
    endtask

    task automatic test_misaligned();
        drive(1'b1, 4'd1, 32'h2, 32'h0, 1'b0, 5'd4, 32'h0, 32'h300);
        #1;
        checks++;
        if ({m_align_err, m_data_byteen} !== {1'b1, 4'b0000}) begin
            errors++;
            $display("FAIL lw_misalign: got err=%b be=%b expected 1/0000", m_align_err, m_data_byteen);
        end
        next_cycle();
        checks++;
        if (w_grf_we !== 1'b0) begin
            errors++;
            $display("FAIL lw_misalign_wb: got we=%b expected 0", w_grf_we);
        end
        drive(1'b1, 4'd7, 32'h1, 32'h0000_1357, 1'b0, 5'd0, 32'h0, 32'h304);
        #1;
        checks++;
        if ({m_align_err, m_data_byteen, m_data_wdata} !== {1'b1, 4'b0000, 32'h0000_1357}) begin
            errors++;
            $display("FAIL sh_misalign: got err=%b be=%b wdata=%h expected 1/0000/00001357",
                     m_align_err, m_data_byteen, m_data_wdata);
        end
        next_cycle();
        $display("txn misaligned lw/sh");
    endtask

    task automatic test_alu_path();
        drive(1'b1, 4'd0, 32'h0, 32'h0, 1'b1, 5'd0, 32'h1111_2222, 32'h400);
        next_cycle();
        checks++;
        if (w_grf_we !== 1'b0) begin
            errors++;
            $display("FAIL alu_zero: got we=%b expected 0", w_grf_we);
        end
        drive(1'b1, 4'd0, 32'h0, 32'h0, 1'b1, 5'd5, 32'hDEAD_BEEF, 32'h404);
        next_cycle();
        checks++;
        if ({w_grf_we, w_grf_addr, w_grf_wdata, w_inst_addr} !== {1'b1, 5'd5, 32'hDEAD_BEEF, 32'h404}) begin
            errors++;
            $display("FAIL alu_wb: got we=%b addr=%0d wdata=%h pc=%h expected 1/5/deadbeef/00000404",
                     w_grf_we, w_grf_addr, w_grf_wdata, w_inst_addr);
        end
        // store carrying a stray reg_we must not write the GRF
        drive(1'b1, 4'd6, 32'hF0, 32'h5, 1'b1, 5'd6, 32'h7, 32'h408);
        next_cycle();
        checks++;
        if (w_grf_we !== 1'b0) begin
            errors++;
            $display("FAIL store_reg_we: got we=%b expected 0", w_grf_we);
        end
        $display("txn alu path rd=5 wdata=%h", 32'hDEAD_BEEF);
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 4'd1, 32'h40, 32'h0, 1'b0, 5'd7, 32'h0, 32'h500);
        reset = 1'b1;
        next_cycle();
        checks++;
        if ({w_grf_we, w_grf_addr, w_grf_wdata, w_inst_addr} !== {1'b0, 5'd0, 32'd0, PC_RESET}) begin
            errors++;
            $display("FAIL reset_mid: got we=%b addr=%0d wdata=%h pc=%h expected 0/0/0/%h",
                     w_grf_we, w_grf_addr, w_grf_wdata, w_inst_addr, PC_RESET);
        end
        reset = 1'b0;
        drive(1'b1, 4'd6, 32'h80, 32'hCAFE_F00D, 1'b0, 5'd0, 32'h0, 32'h504);
        next_cycle();
        drive(1'b1, 4'd1, 32'h80, 32'h0, 1'b0, 5'd9, 32'h0, 32'h508);
        next_cycle();
        checks++;
        if ({w_grf_we, w_grf_addr, w_grf_wdata, w_inst_addr} !== {1'b1, 5'd9, 32'hCAFE_F00D, 32'h508}) begin
            errors++;
            $display("FAIL sw_lw_back_to_back: got we=%b addr=%0d wdata=%h pc=%h expected 1/9/cafef00d/00000508",
                     w_grf_we, w_grf_addr, w_grf_wdata, w_inst_addr);
        end
        $display("txn reset mid-load then sw/lw 0x80");
    endtask

    task automatic test_random();
        logic        v, we;
        logic [3:0]  op;
        logic [31:0] addr, data, alu, pc, word;
        logic [4:0]  rd;
        logic [35:0] st;
        logic        mis, is_load, is_store;
        logic        exp_we;
        logic [31:0] exp_wdata;
        for (int i = 0; i < 64; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        for (int t = 0; t < 300; t++) begin
            v    = ($urandom_range(0, 3) != 0);
            op   = 4'($urandom_range(0, 15));
            addr = $urandom_range(0, 255);
            data = $urandom;
            we   = $urandom_range(0, 1) != 0;
            rd   = 5'($urandom_range(0, 31));
            alu  = $urandom;
            pc   = $urandom;
            drive(v, op, addr, data, we, rd, alu, pc);
            #1;
            mis = ref_misaligned(op, addr);
            st  = ref_store(v, op, addr, data);
            checks++;
            if ({m_data_byteen, m_data_wdata, m_align_err, m_data_addr, m_inst_addr}
                    !== {st, v & mis, addr, pc}) begin
                errors++;
                $display("FAIL rand_m_%0d: got be=%b wdata=%h err=%b addr=%h iaddr=%h expected %b/%h/%b/%h/%h",
                         t, m_data_byteen, m_data_wdata, m_align_err, m_data_addr, m_inst_addr,
                         st[35:32], st[31:0], v & mis, addr, pc);
            end
            word      = ref_mem[addr / 4];
            is_load   = (op >= 1 && op <= 5);
            is_store  = (op >= 6 && op <= 8);
            exp_we    = v && !mis && (is_load || (we && !is_store)) && rd != 0;
            exp_wdata = is_load ? ref_load(op, addr, word) : alu;
            for (int b = 0; b < 4; b++)
                if (st[32 + b])
                    ref_mem[addr / 4] = (ref_mem[addr / 4] & ~(32'hFF << (8 * b)))
                                      | (st[31:0] & (32'hFF << (8 * b)));
            next_cycle();
            checks++;
            if ({w_grf_we, w_grf_addr, w_grf_wdata, w_inst_addr} !== {exp_we, rd, exp_wdata, pc}) begin
                errors++;
                $display("FAIL rand_w_%0d: got we=%b addr=%0d wdata=%h pc=%h expected %b/%0d/%h/%h",
                         t, w_grf_we, w_grf_addr, w_grf_wdata, w_inst_addr, exp_we, rd, exp_wdata, pc);
            end
            $display("txn %0d v=%b op=%0d addr=%h be=%b we=%b wdata=%h",
                     t, v, op, addr, st[35:32], exp_we, exp_wdata);
        end
    endtask

    initial begin
        drive(1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0);
        reset = 1'b1;
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 32'd0;
            ref_mem[i] = 32'd0;
        end
        #1;
        test_reset();
        test_store_word();
        test_store_sub();
        test_load_ext();
        test_misaligned();
        test_alu_path();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_wb_port.md
# mem_wb_port

CPU-side data-memory access and write-back unit for the pipelined MIPS core. It sits at the boundary between the M and W stages and drives the external data-memory port (`m_data_*`, `m_inst_addr`). It latches the M-stage result and the raw memory word into the M/W register. In W it performs load extraction and sign/zero extension, then drives the register-file write port and trace port (`w_grf_*`, `w_inst_addr`). These are exactly the signals the system bench consumes for memory modelling and `$display` tracing.

## Interface
- `PC_RESET`, 32'h0000_0000, value of `w_inst_addr` after reset.
- `clk`  in  1  system clock, all state on posedge.
- `reset`  in  1  synchronous, active-high; clears the M/W register.
- `m_valid`  in  1  M-stage holds a real instruction (0 = bubble).
- `m_pc`  in  32  PC of the M-stage instruction.
- `m_op`  in  4  0 none, 1 lw, 2 lh, 3 lhu, 4 lb, 5 lbu, 6 sw, 7 sh, 8 sb, 9–15 treated as none.
- `m_addr`  in  32  effective address computed in E.
- `m_store_data`  in  32  forwarded rt value.
- `m_reg_we`  in  1  non-load instruction writes GRF.
- `m_rd`  in  5  destination register.
- `m_alu_result`  in  32  write-back value for non-load instructions.
- `m_data_addr`  out  32  equals `m_addr`.
- `m_data_wdata`  out  32  lane-replicated store data.
- `m_data_byteen`  out  4  byte write enables.
- `m_data_rdata`  in  32  word at `m_data_addr>>2`, combinational from memory.
- `m_inst_addr`  out  32  equals `m_pc`.
- `m_align_err`  out  1  misaligned access in M (combinational).
- `w_grf_we`  out  1  GRF write enable.
- `w_grf_addr`  out  5  GRF write address.
- `w_grf_wdata`  out  32  GRF write data.
- `w_inst_addr`  out  32  PC of the W-stage instruction.

## Operation
- Offset is `o = m_addr[1:0]`. An access is misaligned when the op is lw/sw and `o != 0`, or lh/lhu/sh and `o[0] = 1`.
- `m_align_err = m_valid & misaligned`.
- **Stores, when valid and aligned:**
  - sw: byteen 4'b1111, wdata = data.
  - sh: byteen 4'b0011 (`o=0`) or 4'b1100 (`o=2`), wdata = {data[15:0], data[15:0]}.
  - sb: byteen `4'b0001 << o`, wdata = data[7:0] replicated ×4.
- Any non-store, bubble, or misaligned access drives byteen 4'b0000 and wdata = `m_store_data`.
- **M/W register, loaded every posedge:**
  - Captured fields: `valid`, `op`, `o`, `rd`, `reg_we`, `alu_result`, `pc`, `raw = m_data_rdata`, `err = m_align_err`.
  - No stall or enable input: the register advances every cycle.
- **W extraction:**
  - lw: raw.
  - lh/lhu: the half selected by `o[1]` (0 = raw[15:0], 1 = raw[31:16]), sign- or zero-extended.
  - lb/lbu: the byte `raw[8*o+7:8*o]`, sign- or zero-extended.
- **W write-back:**
  - `is_load` = op ∈ {1..5}.
  - `w_grf_we = valid & ~err & (is_load | reg_we) & (rd != 0)`.
  - `w_grf_addr = rd`.
  - `w_grf_wdata` = extracted value for loads, otherwise `alu_result`.
  - `w_inst_addr = pc`.
- A store whose `m_reg_we=1` is not a legal encoding. The load/store op wins: no GRF write occurs for stores.

## Timing
- M-side outputs are purely combinational from M inputs. There is no latency: the memory samples `m_data_byteen`/`m_data_wdata` at the same posedge that advances the instruction to W.
- Load latency: address in M at cycle N, so `w_grf_wdata` is valid in cycle N+1 and the GRF commits at posedge N+2.
- Back-to-back sw then lw to the same word: the lw in M at N+1 sees the updated word (the memory wrote at posedge N+1), so there is no hazard inside this block.
- **Reset:** while `reset=1` at a posedge, the register clears:
  - Outputs become `w_grf_we=0`, `w_grf_addr=0`, `w_grf_wdata=0`, `w_inst_addr=PC_RESET`.
  - M-side outputs remain combinational. Upstream holds `m_valid=0` during reset, so byteen=0.
- Reset asserted while a load sits in M: the load is dropped and no write-back occurs. After deassertion, the first valid M instruction reaches W on the next posedge.
- Bubble (`m_valid=0`): byteen=0 and the next W cycle has `w_grf_we=0`. `w_inst_addr` still tracks `m_pc`.

## Test plan
- Store word: sw, `m_addr=0x10`, data 0x12345678 → byteen 4'b1111, wdata 0x12345678, `m_inst_addr=m_pc`; the next cycle has `w_grf_we=0`.
- Store byte/half: sb, `m_addr=0x23`, data 0x000000AB → byteen 4'b1000, wdata 0xABABABAB. Then sh, `m_addr=0x22`, data 0x0000BEEF → byteen 4'b1100, wdata 0xBEEFBEEF.
- Load extension: `m_data_rdata=0x80FF7F01` with rd=8, one cycle after each request:
  - lb `o=0` → `w_grf_wdata=0x00000001`.
  - lb `o=3` → 0xFFFFFF80.
  - lbu `o=3` → 0x00000080.
  - lh `o=2` → 0xFFFF80FF.
  - lhu `o=0` → 0x00007F01.
  - lw → 0x80FF7F01.
  - Each case has `w_grf_we=1`, `w_grf_addr=8`.
- Misaligned: lw `m_addr=0x2` → `m_align_err=1`, then `w_grf_we=0` next cycle. sh `m_addr=0x1` → byteen 4'b0000.
- $zero and ALU path: addu with rd=0, `m_reg_we=1` → `w_grf_we=0`. With rd=5 and alu_result 0xDEADBEEF → `w_grf_we=1`, `w_grf_wdata=0xDEADBEEF`, `w_inst_addr=m_pc` of the previous cycle.
- Reset mid-operation: lw in M with `reset=1` at the posedge → W outputs read 0/0/0/`PC_RESET`. After release, a sw then lw to the same address returns the stored word.
